// File: rtl/dual_issue_relay_buffer.sv
// Dual-issue relay stage: circular FIFO of single-instruction slots that offers
// the two oldest entries to the execute lanes, demoting to single issue on a hazard.
module dual_issue_relay_buffer #(
   parameter int IW       = 16,
   parameter int DEPTH    = 8,
   parameter int REG_W    = 3,
   parameter int DEST_LSB = 8,
   parameter int SRC1_LSB = 5,
   parameter int SRC2_LSB = 2,
   parameter int IMM_BIT  = 11,
   parameter int DUAL_EN  = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   input  logic                       in_has1,
   input  logic [IW-1:0]              in_instr0,
   input  logic [IW-1:0]              in_instr1,
   output logic                       in_ready,
   input  logic                       out_ready,
   output logic                       out_valid0,
   output logic [IW-1:0]              out_instr0,
   output logic                       out_valid1,
   output logic [IW-1:0]              out_instr1,
   output logic                       issue_single,
   output logic [$clog2(DEPTH):0]     count,
   output logic [15:0]                single_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [IW-1:0] mem_q [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_p1_s, wr_ptr_p1_s;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] push_n_s, pop_n_s;
   logic [15:0]   single_cnt_q, single_cnt_d;
   logic          push_s, pop_s, hazard_s;

   // Register dependency between the older (a) and younger (b) head entries.
   function automatic logic hazard_f(input logic [IW-1:0] a, input logic [IW-1:0] b);
      logic [REG_W-1:0] a_dst, a_s1, a_s2, b_dst, b_s1, b_s2;
      a_dst = a[DEST_LSB +: REG_W];
      a_s1  = a[SRC1_LSB +: REG_W];
      a_s2  = a[SRC2_LSB +: REG_W];
      b_dst = b[DEST_LSB +: REG_W];
      b_s1  = b[SRC1_LSB +: REG_W];
      b_s2  = b[SRC2_LSB +: REG_W];
      hazard_f = (a_dst == b_dst) || (a_dst == b_s1) || (!b[IMM_BIT] && (a_dst == b_s2)) ||
                 (b_dst == a_s1) || (!a[IMM_BIT] && (b_dst == a_s2));
   endfunction

   assign rd_ptr_p1_s  = rd_ptr_q + PW'(1);
   assign wr_ptr_p1_s  = wr_ptr_q + PW'(1);
   assign out_instr0   = mem_q[rd_ptr_q];
   assign out_instr1   = mem_q[rd_ptr_p1_s];
   assign hazard_s     = hazard_f(out_instr0, out_instr1);
   assign out_valid0   = (count_q != CW'(0));
   assign out_valid1   = (DUAL_EN != 0) && (count_q >= CW'(2)) && !hazard_s;
   assign issue_single = (count_q >= CW'(2)) && !out_valid1;
   assign in_ready     = (count_q <= CW'(DEPTH - 2));
   assign count        = count_q;
   assign single_cnt   = single_cnt_q;

   assign push_s   = in_valid && in_ready;
   assign pop_s    = out_ready && out_valid0;
   assign push_n_s = in_has1 ? CW'(2) : CW'(1);
   assign pop_n_s  = out_valid1 ? CW'(2) : CW'(1);

   // Next-state for pointers, occupancy and the single-issue statistic.
   always_comb begin
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      count_d      = count_q;
      single_cnt_d = single_cnt_q;
      if (flush) begin
         rd_ptr_d = PW'(0);
         wr_ptr_d = PW'(0);
         count_d  = CW'(0);
      end else begin
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + push_n_s[PW-1:0];
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + pop_n_s[PW-1:0];
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         count_d = count_q + (push_s ? push_n_s : CW'(0)) - (pop_s ? pop_n_s : CW'(0));
         if (pop_s && issue_single && (single_cnt_q != 16'hFFFF)) begin
            single_cnt_d = single_cnt_q + 16'd1;
         end else begin
            single_cnt_d = single_cnt_q;
         end
      end
   end

   // Control state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q     <= PW'(0);
         wr_ptr_q     <= PW'(0);
         count_q      <= CW'(0);
         single_cnt_q <= 16'd0;
      end else begin
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         single_cnt_q <= single_cnt_d;
      end
   end

   // Slot storage; contents need no reset since occupancy gates their use.
   always_ff @(posedge clk) begin
      if (push_s && !flush) begin
         mem_q[wr_ptr_q] <= in_instr0;
         if (in_has1) begin
            mem_q[wr_ptr_p1_s] <= in_instr1;
         end
      end
   end

endmodule

// File: tb/tb_dual_issue_relay_buffer.sv
// Scoreboard bench for dual_issue_relay_buffer: pushed instructions and status
// expectations are queued by the stimulus and compared by a negedge monitor.
module tb_dual_issue_relay_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush, in_valid, in_has1, out_ready;
   logic [15:0] in_instr0, in_instr1;
   logic        in_ready, out_valid0, out_valid1, issue_single;
   logic [15:0] out_instr0, out_instr1, single_cnt;
   logic [3:0]  count;

   logic        d_in_valid, d_in_has1, d_out_ready;
   logic [15:0] d_in_instr0, d_in_instr1;
   logic        d_in_ready, d_out_valid0, d_out_valid1, d_issue_single;
   logic [15:0] d_out_instr0, d_out_instr1, d_single_cnt;
   logic [3:0]  d_count;

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] exp;
   } chk_t;

   chk_t        chk_q[$];
   logic [15:0] exp_q[$];
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   dual_issue_relay_buffer #(.DUAL_EN(1)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_has1(in_has1),
      .in_instr0(in_instr0), .in_instr1(in_instr1), .in_ready(in_ready),
      .out_ready(out_ready), .out_valid0(out_valid0), .out_instr0(out_instr0),
      .out_valid1(out_valid1), .out_instr1(out_instr1), .issue_single(issue_single),
      .count(count), .single_cnt(single_cnt));

   dual_issue_relay_buffer #(.DUAL_EN(0)) dut_single (
      .clk(clk), .rst(rst), .flush(1'b0), .in_valid(d_in_valid), .in_has1(d_in_has1),
      .in_instr0(d_in_instr0), .in_instr1(d_in_instr1), .in_ready(d_in_ready),
      .out_ready(d_out_ready), .out_valid0(d_out_valid0), .out_instr0(d_out_instr0),
      .out_valid1(d_out_valid1), .out_instr1(d_out_instr1), .issue_single(d_issue_single),
      .count(d_count), .single_cnt(d_single_cnt));

   function automatic logic [31:0] sample(input int sel);
      case (sel)
         0:       sample = {31'd0, out_valid0};
         1:       sample = {31'd0, out_valid1};
         2:       sample = {31'd0, issue_single};
         3:       sample = {28'd0, count};
         4:       sample = {16'd0, single_cnt};
         5:       sample = {31'd0, in_ready};
         6:       sample = {16'd0, out_instr0};
         7:       sample = {31'd0, d_out_valid0};
         8:       sample = {31'd0, d_out_valid1};
         9:       sample = {31'd0, d_issue_single};
         10:      sample = {16'd0, d_single_cnt};
         11:      sample = {16'd0, d_out_instr0};
         12:      sample = {28'd0, d_count};
         default: sample = 32'hDEAD_BEEF;
      endcase
   endfunction

   // Monitor: status expectations plus in-order data checks on every pop.
   always @(negedge clk) begin
      chk_t        c;
      logic [31:0] act;
      logic [15:0] e;
      while (chk_q.size() > 0) begin
         c   = chk_q.pop_front();
         act = sample(c.sel);
         checks++;
         if (act !== c.exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", c.name, act, c.exp);
         end
      end
      if (!rst && !flush && out_valid0 && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pop0: got %0h expected nothing", out_instr0);
         end else begin
            e = exp_q.pop_front();
            if (out_instr0 !== e) begin
               errors++;
               $display("FAIL pop0: got %0h expected %0h", out_instr0, e);
            end
         end
         if (out_valid1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL pop1: got %0h expected nothing", out_instr1);
            end else begin
               e = exp_q.pop_front();
               if (out_instr1 !== e) begin
                  errors++;
                  $display("FAIL pop1: got %0h expected %0h", out_instr1, e);
               end
            end
         end
      end
   end

   task automatic expect_(input string name, input int sel, input logic [31:0] exp);
      chk_t c;
      c.name = name;
      c.sel  = sel;
      c.exp  = exp;
      chk_q.push_back(c);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_pair(input logic [15:0] a, input logic [15:0] b);
      in_valid  = 1'b1;
      in_has1   = 1'b1;
      in_instr0 = a;
      in_instr1 = b;
      exp_q.push_back(a);
      exp_q.push_back(b);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_has1 = 1'b0; out_ready = 1'b0;
      in_instr0 = 16'd0; in_instr1 = 16'd0;
      d_in_valid = 1'b0; d_in_has1 = 1'b0; d_out_ready = 1'b0;
      d_in_instr0 = 16'd0; d_in_instr1 = 16'd0;
      #1;
      expect_("rst_in_ready", 5, 32'd1);
      expect_("rst_valid0", 0, 32'd0);
      expect_("rst_valid1", 1, 32'd0);
      expect_("rst_single", 2, 32'd0);
      expect_("rst_count", 3, 32'd0);
      expect_("rst_single_cnt", 4, 32'd0);
      tick(); tick();
      rst = 1'b0;

      // 1: independent pair dual-issues
      tick(); push_pair(16'h014C, 16'h06E0);
      tick(); in_valid = 1'b0;
      expect_("t1_valid0", 0, 32'd1);
      expect_("t1_valid1", 1, 32'd1);
      expect_("t1_single", 2, 32'd0);
      expect_("t1_count", 3, 32'd2);
      out_ready = 1'b1;
      tick(); out_ready = 1'b0;
      expect_("t1_count_after", 3, 32'd0);
      expect_("t1_valid0_after", 0, 32'd0);

      // 2: B.src1 == A.dest forces single issue
      push_pair(16'h014C, 16'h0434);
      tick(); in_valid = 1'b0;
      expect_("t2_valid1", 1, 32'd0);
      expect_("t2_single", 2, 32'd1);
      out_ready = 1'b1;
      tick(); out_ready = 1'b0;
      expect_("t2_single_cnt", 4, 32'd1);
      expect_("t2_count", 3, 32'd1);
      expect_("t2_head", 6, 32'h0434);
      expect_("t2_valid1_cnt1", 1, 32'd0);
      expect_("t2_single_cnt1", 2, 32'd0);
      out_ready = 1'b1;
      tick(); out_ready = 1'b0;
      expect_("t2_drained", 3, 32'd0);
      expect_("t2_single_cnt_hold", 4, 32'd1);

      // 3: immediate form ignores src2 match
      push_pair(16'h014C, 16'h0C64);
      tick(); in_valid = 1'b0;
      expect_("t3_valid1", 1, 32'd1);
      expect_("t3_single", 2, 32'd0);
      out_ready = 1'b1;
      tick(); out_ready = 1'b0;
      expect_("t3_count", 3, 32'd0);

      // 4: fill to full, reject push when full, then stream across the wrap
      push_pair(16'h0900, 16'h0A00); tick();
      push_pair(16'h0B00, 16'h0C00); tick();
      push_pair(16'h0D00, 16'h0E00); tick();
      push_pair(16'h0F00, 16'h0900); tick();
      in_valid = 1'b1; in_has1 = 1'b1; in_instr0 = 16'h0123; in_instr1 = 16'h0456;
      expect_("t4_full_count", 3, 32'd8);
      expect_("t4_full_in_ready", 5, 32'd0);
      tick(); in_valid = 1'b0;
      expect_("t4_full_hold", 3, 32'd8);
      out_ready = 1'b1;
      tick();
      expect_("t4_count6", 3, 32'd6);
      push_pair(16'h0A00, 16'h0B00); tick();
      push_pair(16'h0C00, 16'h0D00); tick();
      push_pair(16'h0E00, 16'h0F00); tick();
      in_valid = 1'b0;
      expect_("t4_stream_count", 3, 32'd6);
      tick(); tick(); tick();
      out_ready = 1'b0;
      expect_("t4_drained", 3, 32'd0);
      expect_("t4_single_cnt", 4, 32'd1);

      // 5: flush beats a same-cycle push and pop
      push_pair(16'h0900, 16'h0A00);
      tick();
      in_valid = 1'b1; in_has1 = 1'b1; in_instr0 = 16'h0B00; in_instr1 = 16'h0C00;
      out_ready = 1'b1; flush = 1'b1;
      exp_q.delete();
      tick();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      expect_("t5_count", 3, 32'd0);
      expect_("t5_valid0", 0, 32'd0);
      expect_("t5_in_ready", 5, 32'd1);
      expect_("t5_single_cnt", 4, 32'd1);
      in_valid = 1'b1; in_has1 = 1'b0; in_instr0 = 16'h0D00; exp_q.push_back(16'h0D00);
      tick(); in_valid = 1'b0;
      expect_("t5_single_push", 3, 32'd1);
      expect_("t5_head", 6, 32'h0D00);
      out_ready = 1'b1;
      tick(); out_ready = 1'b0;
      expect_("t5_empty", 3, 32'd0);

      // 6: DUAL_EN=0 issues one per cycle
      d_in_valid = 1'b1; d_in_has1 = 1'b1; d_in_instr0 = 16'h0900; d_in_instr1 = 16'h0A00;
      tick(); d_in_valid = 1'b0;
      expect_("t6_valid0", 7, 32'd1);
      expect_("t6_valid1", 8, 32'd0);
      expect_("t6_single", 9, 32'd1);
      expect_("t6_head0", 11, 32'h0900);
      expect_("t6_count", 12, 32'd2);
      d_out_ready = 1'b1;
      tick();
      expect_("t6_single_cnt1", 10, 32'd1);
      expect_("t6_head1", 11, 32'h0A00);
      expect_("t6_single_cnt_lvl", 9, 32'd0);
      expect_("t6_count1", 12, 32'd1);
      tick(); d_out_ready = 1'b0;
      expect_("t6_count0", 12, 32'd0);
      expect_("t6_single_cnt_final", 10, 32'd1);

      // async reset between clock edges
      push_pair(16'h0900, 16'h0A00);
      tick(); in_valid = 1'b0;
      expect_("ar_count_before", 3, 32'd2);
      tick();
      #2;
      rst = 1'b1;
      exp_q.delete();
      #1;
      expect_("ar_count", 3, 32'd0);
      expect_("ar_valid0", 0, 32'd0);
      expect_("ar_in_ready", 5, 32'd1);
      expect_("ar_single_cnt", 4, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
